inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_W, default INST_SIZE (from package constant), instruction BRAM word-address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000, maximum idle cycles between received bytes before abort.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data holds a received byte.
REQ-006 rx_data  input  8  received byte.
REQ-007 restart  input  1  one-cycle request to return from DONE/ERR to IDLE.
REQ-008 mode  output  3  core mode: STALL=0, LOAD=1, EXEC=2.
REQ-009 bram_addr  output  ADDR_W  instruction BRAM write word-address.
REQ-010 bram_din  output  32  instruction BRAM write data.
REQ-011 bram_we  output  1  instruction BRAM write enable, one cycle per word.
REQ-012 words_loaded  output  ADDR_W+1  count of words written this load.
REQ-013 done  output  1  high while in DONE.
REQ-014 err  output  1  high while in ERR.

Function
REQ-015 States SHALL be IDLE, HDR, DATA, CSUM, DONE, ERR.
REQ-016 mode SHALL be STALL in IDLE/ERR, LOAD in HDR/DATA/CSUM, EXEC in DONE.
REQ-017 IDLE: first rx_valid SHALL move to HDR with that byte taken as header byte 0.
REQ-018 HDR: 4 bytes, little-endian, form word count N; after byte 3, N==0 -> DONE (or CSUM if checksum enabled), N>2**ADDR_W -> ERR, else DATA.
REQ-019 DATA: bytes assembled little-endian into 32-bit words; on 4th byte bram_we SHALL pulse next cycle with bram_addr=word index (0-based) and bram_din=assembled word.
REQ-020 Write latency: bram_we asserted exactly 1 cycle after the rx_valid carrying the word's last byte.
REQ-021 words_loaded SHALL increment in the bram_we cycle; after word N written -> DONE (or CSUM).
REQ-022 Byte counter SHALL wrap 3->0; bram_addr SHALL not wrap within a load (guaranteed by REQ-018 check).
REQ-023 Timeout: in HDR/DATA/CSUM, a counter SHALL reset on each rx_valid; reaching TIMEOUT_CYCLES -> ERR.
REQ-024 rx_valid in DONE/ERR SHALL be ignored; no BRAM write outside DATA.
REQ-025 restart in DONE/ERR -> IDLE next cycle, clearing words_loaded; restart in other states ignored.
REQ-026 rx_valid and timeout expiry in same cycle: byte SHALL be accepted, timeout discarded.

Reset
REQ-027 rstn low SHALL asynchronously force IDLE, mode=STALL, bram_we=0, bram_addr=0, bram_din=0, words_loaded=0, done=0, err=0, all counters 0.
REQ-028 Reset mid-load SHALL abort with no further BRAM writes; partial contents left unspecified.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: after header N and N words, 4 further bytes (little-endian) SHALL be compared with mod-2^32 sum of all N data words; match -> DONE, mismatch -> ERR.
REQ-030 LOADER_CHECKSUM_EN undefined: CSUM state and sum register absent; last word (or N==0 header) -> DONE directly.

Structure
REQ-031 Package constant SHALL hold mode encodings (STALL/LOAD/EXEC) and INST_SIZE; loader state enum typedef SHALL live in the same package.
REQ-032 One sub-module, byte_packer (byte-to-word assembler with byte counter and word-valid strobe), SHALL be instantiated; the rest is a single FSM.

Verification
REQ-033 Header 02 00 00 00, data 11 22 33 44 55 66 77 88 -> writes addr0=0x44332211, addr1=0x88776655; done=1, mode=EXEC, words_loaded=2.
REQ-034 Header 00 00 00 00 -> DONE, no bram_we (checksum off); with LOADER_CHECKSUM_EN, checksum 00 00 00 00 -> DONE.
REQ-035 Header N=2**ADDR_W+1 -> err=1, mode=STALL, zero writes.
REQ-036 Header N=3, 5 data bytes then silence for TIMEOUT_CYCLES -> ERR with exactly 1 write; restart -> IDLE, words_loaded=0.
REQ-037 LOADER_CHECKSUM_EN, words 0x00000001 and 0xFFFFFFFF, checksum 00 00 00 00 -> DONE; checksum 01 00 00 00 -> ERR.
REQ-038 rstn pulsed low mid-DATA -> outputs reset immediately, no bram_we afterwards; new load then succeeds.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared constants and types for the instruction loader: mode encodings,
// default BRAM depth and the loader state enum.
package inst_loader_pkg;

    localparam int unsigned INST_SIZE = 10;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned MODE_W    = 3;

    localparam logic [MODE_W-1:0] MODE_STALL = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_EXEC  = 3'd2;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_HDR,
        LD_DATA,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } ld_state_e;

    function automatic logic [MODE_W-1:0] state_mode(input ld_state_e s);
        case (s)
            LD_HDR, LD_DATA, LD_CSUM: state_mode = MODE_LOAD;
            LD_DONE:                  state_mode = MODE_EXEC;
            default:                  state_mode = MODE_STALL;
        endcase
    endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word_valid_c fires combinationally
// with the fourth byte so the loader can register the write one cycle later.
module inst_loader_byte_packer
    import inst_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

    logic [1:0]         cnt_q, cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            // two-bit counter wraps 3 -> 0 at the end of each word
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    shift_d[7:0]   = byte_data;
                2'd1:    shift_d[15:8]  = byte_data;
                2'd2:    shift_d[23:16] = byte_data;
                default: shift_d        = shift_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_c = byte_valid && !clr && (cnt_q == 2'd3);
    assign word_c       = {byte_data, shift_q};

endmodule

// File: rtl/inst_loader.sv
// Byte-stream instruction loader: header word count, data words into BRAM,
// idle timeout. Define LOADER_CHECKSUM_EN to require a trailing sum word.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = INST_SIZE,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              restart,
    output logic [MODE_W-1:0] mode,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WORD_W-1:0] bram_din,
    output logic              bram_we,
    output logic [ADDR_W:0]   words_loaded,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [63:0] MAX_WORDS = 64'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_e TAIL_ST = LD_CSUM;
`else
    localparam ld_state_e TAIL_ST = LD_DONE;
`endif

    ld_state_e         state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  wl_q, wl_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
`endif

    logic              pk_clr_c;
    logic              pk_valid_c;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;
    logic [TMO_W-1:0]  tmo_inc_c;
    logic [CNT_W-1:0]  wl_inc_c;
    logic              busy_c;

    // DONE/ERR ignore the byte stream and hold the assembler empty
    assign pk_clr_c   = (state_q == LD_DONE) || (state_q == LD_ERR);
    assign pk_valid_c = rx_valid && !pk_clr_c;

    inst_loader_byte_packer u_byte_packer (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (pk_clr_c),
        .byte_valid   (pk_valid_c),
        .byte_data    (rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    assign tmo_inc_c = tmo_q + TMO_W'(1);
    assign wl_inc_c  = wl_q + CNT_W'(1);
    assign busy_c    = (state_q == LD_HDR) || (state_q == LD_DATA) || (state_q == LD_CSUM);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wl_d    = wl_q;
        tmo_d   = '0;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        // an arriving byte always wins over a simultaneous expiry
        if (busy_c && !rx_valid) begin
            tmo_d = tmo_inc_c;
            if (tmo_inc_c == TMO_W'(TIMEOUT_CYCLES)) begin
                state_d = LD_ERR;
            end
        end

        case (state_q)
            LD_IDLE: begin
`ifdef LOADER_CHECKSUM_EN
                sum_d = '0;
`endif
                if (rx_valid) begin
                    state_d = LD_HDR;
                end
            end
            LD_HDR: begin
                if (word_valid_c) begin
                    if (word_c == '0) begin
                        state_d = TAIL_ST;
                    end else if ({32'd0, word_c} > MAX_WORDS) begin
                        state_d = LD_ERR;
                    end else begin
                        n_d     = CNT_W'(word_c);
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (word_valid_c) begin
                    we_d   = 1'b1;
                    addr_d = wl_q[ADDR_W-1:0];
                    din_d  = word_c;
                    wl_d   = wl_inc_c;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + word_c;
`endif
                    if (wl_inc_c == n_q) begin
                        state_d = TAIL_ST;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CSUM: begin
                if (word_valid_c) begin
                    state_d = (word_c == sum_q) ? LD_DONE : LD_ERR;
                end
            end
`endif
            LD_DONE, LD_ERR: begin
                if (restart) begin
                    state_d = LD_IDLE;
                    wl_d    = '0;
                    n_d     = '0;
                end
            end
            default: state_d = LD_IDLE;
        endcase

        mode_d = state_mode(state_d);
        done_d = (state_d == LD_DONE);
        err_d  = (state_d == LD_ERR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LD_IDLE;
            n_q     <= '0;
            wl_q    <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            mode_q  <= MODE_STALL;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wl_q    <= wl_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign mode         = mode_q;
    assign bram_addr    = addr_q;
    assign bram_din     = din_q;
    assign bram_we      = we_q;
    assign words_loaded = wl_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: vector table, random loads against a
// stream-level model, and directed timeout/reset/ignore sequences.
module tb_inst_loader;

    localparam int unsigned AW   = 3;
    localparam int unsigned TMO  = 40;
    localparam int unsigned MAXN = 1 << AW;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq32_t[$];
    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    typedef struct {
        logic [31:0] n;
        logic [31:0] base;
        logic [31:0] step;
        logic        exp_done;
        logic        exp_err;
        int unsigned exp_wl;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          restart;
    logic [2:0]    mode;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;
    logic          bram_we;
    logic [AW:0]   words_loaded;
    logic          done;
    logic          err;

    inst_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .restart      (restart),
        .mode         (mode),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .bram_we      (bram_we),
        .words_loaded (words_loaded),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   lat_bad = 0;
    logic rxv_edge = 1'b0;
    wr_t  wq[$];

    always @(posedge clk) rxv_edge <= rx_valid;

    // captured writes; each must follow a cycle in which a byte was presented
    always @(negedge clk) begin
        if (bram_we) begin
            wq.push_back('{bram_addr, bram_din});
            if (!rxv_edge) lat_bad++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bq_t le(input bq_t q, input logic [31:0] w);
        return {q, w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        if (gap > 0) idle(gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t q, input int maxgap);
        foreach (q[i]) send_byte(q[i], int'($urandom_range(maxgap, 0)));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        idle(1);
        restart = 1'b0;
    endtask

    // compare outputs and captured writes, then return the loader to IDLE
    task automatic check_load(input string nm, input wq32_t ew, input logic edone,
                              input logic eerr, input int unsigned ewl);
        chk({nm, "_nwr"}, 64'(wq.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
            chk({nm, "_addr"}, 64'(wq[i].a), 64'(i));
            chk({nm, "_din"}, 64'(wq[i].d), 64'(ew[i]));
        end
        chk({nm, "_done"}, 64'(done), 64'(edone));
        chk({nm, "_err"}, 64'(err), 64'(eerr));
        chk({nm, "_mode"}, 64'(mode), edone ? 64'd2 : 64'd0);
        chk({nm, "_wl"}, 64'(words_loaded), 64'(ewl));
        do_restart();
        chk({nm, "_rst_mode"}, 64'(mode), 64'd0);
        chk({nm, "_rst_wl"}, 64'(words_loaded), 64'd0);
        chk({nm, "_rst_flags"}, 64'({done, err}), 64'd0);
        wq.delete();
    endtask

    vec_t        tbl[7];
    bq_t         s;
    bq_t         empty_q;
    wq32_t       ew;
    logic [31:0] w;
    logic [31:0] sum;
    int unsigned n;
    logic        bad;
    logic        edone;

    initial begin
        tbl[0] = '{32'd2,          32'h44332211, 32'h44444444, 1'b1, 1'b0, 2};
        tbl[1] = '{32'd0,          32'h0,        32'h0,        1'b1, 1'b0, 0};
        tbl[2] = '{32'd9,          32'h0,        32'h0,        1'b0, 1'b1, 0};
        tbl[3] = '{32'd8,          32'h0,        32'h1,        1'b1, 1'b0, 8};
        tbl[4] = '{32'd1,          32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1};
        tbl[5] = '{32'h00000100,   32'h0,        32'h0,        1'b0, 1'b1, 0};
        tbl[6] = '{32'h80000002,   32'h0,        32'h0,        1'b0, 1'b1, 0};

        rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; restart = 1'b0;
        #23;
        chk("reset_mode", 64'(mode), 64'd0);
        chk("reset_we", 64'(bram_we), 64'd0);
        chk("reset_addr", 64'(bram_addr), 64'd0);
        chk("reset_din", 64'(bram_din), 64'd0);
        chk("reset_wl", 64'(words_loaded), 64'd0);
        chk("reset_flags", 64'({done, err}), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);

        // vector table
        for (int i = 0; i < 7; i++) begin
            s = le(empty_q, tbl[i].n);
            ew.delete();
            sum = '0;
            if (!tbl[i].exp_err) begin
                for (int j = 0; j < int'(tbl[i].n); j++) begin
                    w = tbl[i].base + 32'(j) * tbl[i].step;
                    ew.push_back(w);
                    s = le(s, w);
                    sum = sum + w;
                end
`ifdef LOADER_CHECKSUM_EN
                s = le(s, sum);
`endif
            end
            send_stream(s, 3);
            idle(3);
            check_load($sformatf("vec%0d", i), ew, tbl[i].exp_done, tbl[i].exp_err,
                       tbl[i].exp_wl);
        end

        // random loads against the stream-level model
        for (int r = 0; r < 20; r++) begin
            n   = $urandom_range(MAXN + 2, 0);
            bad = ($urandom_range(3, 0) == 0);
            s   = le(empty_q, 32'(n));
            ew.delete();
            sum = '0;
            if (n > MAXN) begin
                send_stream(s, 3);
                idle(3);
                check_load($sformatf("rnd%0d", r), ew, 1'b0, 1'b1, 0);
            end else begin
                for (int j = 0; j < int'(n); j++) begin
                    w = $urandom;
                    ew.push_back(w);
                    s = le(s, w);
                    sum = sum + w;
                end
                edone = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                s = le(s, bad ? sum + 32'd1 : sum);
                edone = !bad;
`endif
                send_stream(s, 3);
                idle(3);
                check_load($sformatf("rnd%0d", r), ew, edone, !edone, n);
            end
        end

        // byte arriving on the expiry cycle is accepted; restart while loading is ignored
        send_byte(8'h01, 0);
        chk("hdr_mode", 64'(mode), 64'd1);
        do_restart();
        chk("hdr_restart_ignored", 64'(mode), 64'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, TMO - 1);
        s = le(empty_q, 32'hA5A50F0F);
`ifdef LOADER_CHECKSUM_EN
        s = le(s, 32'hA5A50F0F);
`endif
        send_byte(s[0], TMO - 1);
        for (int i = 1; i < s.size(); i++) send_byte(s[i], 0);
        idle(3);
        ew.delete(); ew.push_back(32'hA5A50F0F);
        check_load("edge_accept", ew, 1'b1, 1'b0, 1);

        // timeout after one full word and one stray byte
        s = le(empty_q, 32'd3);
        s = {s, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_stream(s, 0);
        idle(TMO - 1);
        chk("tmo_before", 64'({err, mode}), 64'({1'b0, 3'd1}));
        idle(1);
        chk("tmo_at", 64'({err, mode}), 64'({1'b1, 3'd0}));
        ew.delete(); ew.push_back(32'h44332211);
        check_load("timeout", ew, 1'b0, 1'b1, 1);

        // bytes in DONE are ignored
        s = le(empty_q, 32'd1);
        s = le(s, 32'h12345678);
`ifdef LOADER_CHECKSUM_EN
        s = le(s, 32'h12345678);
`endif
        send_stream(s, 2);
        idle(2);
        s = le(empty_q, 32'd2);
        s = le(s, 32'hCAFEF00D);
        send_stream(s, 1);
        idle(3);
        ew.delete(); ew.push_back(32'h12345678);
        check_load("done_ignore", ew, 1'b1, 1'b0, 1);

        // asynchronous reset in the middle of DATA
        s = le(empty_q, 32'd4);
        s = le(s, 32'hFEEDC0DE);
        s = {s, 8'hAA, 8'hBB};
        send_stream(s, 1);
        chk("mid_writes", 64'(wq.size()), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_out", 64'({bram_we, bram_addr, bram_din, words_loaded, done, err, mode}), 64'd0);
        wq.delete();
        idle(2);
        rstn = 1'b1;
        send_byte(8'h99, 1);
        idle(TMO + 5);
        chk("post_rst_nowr", 64'(wq.size()), 64'd0);
        do_restart();
        s = le(empty_q, 32'd2);
        s = le(s, 32'h0BADBEEF);
        s = le(s, 32'h00C0FFEE);
`ifdef LOADER_CHECKSUM_EN
        s = le(s, 32'h0BADBEEF + 32'h00C0FFEE);
`endif
        send_stream(s, 2);
        idle(3);
        ew.delete(); ew.push_back(32'h0BADBEEF); ew.push_back(32'h00C0FFEE);
        check_load("after_reset", ew, 1'b1, 1'b0, 2);

`ifdef LOADER_CHECKSUM_EN
        // checksum wraps modulo 2^32
        for (int k = 0; k < 2; k++) begin
            s = le(empty_q, 32'd2);
            s = le(s, 32'h00000001);
            s = le(s, 32'hFFFFFFFF);
            s = le(s, 32'(k));
            send_stream(s, 1);
            idle(3);
            ew.delete(); ew.push_back(32'h00000001); ew.push_back(32'hFFFFFFFF);
            check_load($sformatf("csum%0d", k), ew, k == 0, k == 1, 2);
        end
`endif

        chk("write_latency", 64'(lat_bad), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
